pkt_modport: RTL and testbench
==============================

# pkt_modport

Packet-side loopback buffer for the 10G MAC packet interface. Accepts 64-bit packet words on the `pkt_tx_*` port into an internal FIFO. Once a complete packet (SOP..EOP) is stored, it presents the packet on the `pkt_rx_*` port for reading with a one-cycle read latency. It sits where the MAC core attaches to the packet interface and gives the verification environment a self-contained packet path (TX in, RX out).

## Interface
- `DEPTH_LOG2`, 6: FIFO depth is 2^DEPTH_LOG2 words (default 64).
- `FULL_MARGIN`, 4: `pkt_tx_full` asserts when free entries ≤ FULL_MARGIN.
- `clk_156m25` in 1: 156.25 MHz clock. All logic is on the rising edge.
- `reset_156m25_n` in 1: reset. One clock; reset is synchronous and active-high (asserted = 1, despite the `_n` suffix).
- `pkt_tx_data` in 64: TX word. Byte 0 is in bits [63:56].
- `pkt_tx_val` in 1: TX word valid.
- `pkt_tx_sop` in 1: first word of packet (qualified by val).
- `pkt_tx_eop` in 1: last word of packet (qualified by val).
- `pkt_tx_mod` in 3: valid bytes in EOP word; 0 = all 8.
- `pkt_tx_full` out 1: FIFO nearly full; the source stops writing.
- `pkt_rx_ren` in 1: read enable.
- `pkt_rx_avail` out 1: at least one complete packet is stored.
- `pkt_rx_data` out 64: RX word.
- `pkt_rx_val` out 1: RX word valid.
- `pkt_rx_sop` out 1: RX first word.
- `pkt_rx_eop` out 1: RX last word.
- `pkt_rx_mod` out 3: RX valid bytes on EOP word. It is 0 on non-EOP words.
- `pkt_rx_err` out 1: RX packet error, flagged on the EOP word.

## Operation
- FIFO entry is 70 bits: {data, sop, eop, mod, err}. Write and read pointers are DEPTH_LOG2+1 bits wide so wrap-around can be detected. Occupancy = wptr − rptr, modulo 2^(DEPTH_LOG2+1).
- Write framing state:
  - IDLE: a val+sop word is stored and the state moves to IN_PKT. If that word also has eop, the state stays IDLE.
  - IDLE: a val word without sop is discarded.
  - IN_PKT: every val word is stored. A val+eop word returns the state to IDLE.
  - IN_PKT: a val+sop word (missing EOP) sets `err_pend` and starts a new packet.
- Stored mod is forced to 0 when eop = 0.
- Overflow: a val word arriving with occupancy = depth is discarded and sets `err_pend`.
- Storing an EOP word writes err = `err_pend` and clears `err_pend`.
- `pkt_cnt` increments on each EOP written and decrements on each EOP read. When both occur in the same cycle, `pkt_cnt` is unchanged.
- `pkt_rx_avail` = (`pkt_cnt` ≠ 0).
- Read: `pkt_rx_ren` = 1 with occupancy > 0 pops one word. The next cycle shows val = 1 with that word's fields.
- Read: `pkt_rx_ren` = 1 with an empty FIFO gives val = 0 the next cycle. This is not an error.
- Reads are not restricted to packet boundaries. Reading past EOP continues into following stored words, including a partially written packet.
- When val = 0, `pkt_rx_sop`/`pkt_rx_eop`/`pkt_rx_err`/`pkt_rx_mod` are 0. `pkt_rx_data` holds its last value.
- Simultaneous read and write in one cycle both take effect, including at full (the write uses the freed slot only on the following cycle) and at empty (no bypass).

## Timing
- Reset (synchronous, active-high, one or more cycles) clears:
  - pointers, `pkt_cnt`, `err_pend`, and framing state (to IDLE);
  - all outputs, which read 0: `pkt_tx_full`, `pkt_rx_avail`, `pkt_rx_val`, `pkt_rx_sop`, `pkt_rx_eop`, `pkt_rx_mod`, `pkt_rx_err`, and `pkt_rx_data` = 64'h0.
- Reset mid-packet discards all stored words. Inputs are ignored while reset is asserted.
- Write at edge N: the occupancy, `pkt_cnt`, `pkt_tx_full` and `pkt_rx_avail` changes are visible from edge N (sampled at edge N+1).
- Read latency is one cycle: ren sampled at edge M puts the data on the outputs at edge M, sampled at edge M+1. Back-to-back ren streams one word per cycle.
- `pkt_tx_full` is derived from registered occupancy. FULL_MARGIN absorbs the source's one-cycle reaction delay.

## Configuration
- `PKT_MODPORT_ERR_CHECK_EN`:
  - Defined: framing and overflow error marking as specified above.
  - Undefined: `err_pend` logic is removed and `pkt_rx_err` is tied to 0. Overflow words are still discarded. A sop inside IN_PKT silently starts a new packet. Val words without sop in IDLE are discarded.

## Test plan
- Reset: assert reset 2 cycles → all outputs 0, `pkt_rx_avail` = 0, `pkt_tx_full` = 0.
- Single packet: 3 words (sop data 64'h1111_2222_3333_4444, middle, eop with mod = 5) → `pkt_rx_avail` = 1 one cycle after EOP. 3 ren cycles return identical words with sop/eop at positions 1/3, mod = 5, err = 0. Then avail = 0.
- Read when empty: ren = 1 with no data → `pkt_rx_val` = 0, no pointer movement.
- Fill: write 64 single-word (sop+eop) packets without reading → `pkt_tx_full` = 1 once occupancy reaches 60. The 65th word is discarded. The next stored EOP reads back err = 1 (with the macro defined).
- Framing: sop, data, sop (no eop), eop → 4 words stored, one complete packet counted. The final EOP reads err = 1.
- Concurrent: stream writes and reads at 1 word/cycle for 200 cycles → data order preserved, occupancy stays ≤ 2, no loss, no err.

Source files
------------

// File: rtl/pkt_modport.sv
// Packet loopback buffer: framed TX words go into a FIFO and are read back on the RX side.
// Optional framing/overflow error marking is enabled by defining PKT_MODPORT_ERR_CHECK_EN.
module pkt_modport #(
    parameter int unsigned DEPTH_LOG2  = 6,
    parameter int unsigned FULL_MARGIN = 4
) (
    input  logic        clk_156m25,
    input  logic        reset_156m25_n,
    input  logic [63:0] pkt_tx_data,
    input  logic        pkt_tx_val,
    input  logic        pkt_tx_sop,
    input  logic        pkt_tx_eop,
    input  logic [2:0]  pkt_tx_mod,
    output logic        pkt_tx_full,
    input  logic        pkt_rx_ren,
    output logic        pkt_rx_avail,
    output logic [63:0] pkt_rx_data,
    output logic        pkt_rx_val,
    output logic        pkt_rx_sop,
    output logic        pkt_rx_eop,
    output logic [2:0]  pkt_rx_mod,
    output logic        pkt_rx_err
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned PW    = DEPTH_LOG2 + 1;
    localparam logic [PW-1:0] DEPTH_P  = PW'(DEPTH);
    localparam logic [PW-1:0] MARGIN_P = PW'(FULL_MARGIN);

    typedef enum logic [0:0] {
        StIdle,
        StInPkt
    } state_e;

    // Entry layout: [69:6] data, [5] sop, [4] eop, [3:1] mod, [0] err
    logic [69:0]   r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [PW-1:0] r_pkt_cnt;
    state_e        r_state;
    state_e        w_state_nxt;

    logic [PW-1:0] w_occ;
    logic [PW-1:0] w_free;
    logic          w_at_depth;
    logic          w_store;
    logic          w_ovf;
    logic          w_frame_err;
    logic          w_wr_err;
    logic          w_pop;
    logic [69:0]   w_rd_entry;
    logic [69:0]   w_wr_entry;
    logic          w_cnt_inc;
    logic          w_cnt_dec;

    logic [63:0]   r_rx_data;
    logic          r_rx_val;
    logic          r_rx_sop;
    logic          r_rx_eop;
    logic [2:0]    r_rx_mod;
    logic          r_rx_err;

    assign w_occ      = r_wptr - r_rptr;
    assign w_free     = DEPTH_P - w_occ;
    assign w_at_depth = (w_occ == DEPTH_P);
    assign w_pop      = pkt_rx_ren && (w_occ != '0);
    assign w_rd_entry = r_mem[r_rptr[PW-2:0]];

    // Framing FSM: decides whether the incoming word is stored or dropped
    always_comb begin
        w_state_nxt = r_state;
        w_store     = 1'b0;
        w_ovf       = 1'b0;
        w_frame_err = 1'b0;
        if (pkt_tx_val) begin
            if (w_at_depth) begin
                w_ovf = 1'b1;
            end else begin
                unique case (r_state)
                    StIdle: begin
                        if (pkt_tx_sop) begin
                            w_store = 1'b1;
                            if (!pkt_tx_eop) w_state_nxt = StInPkt;
                        end
                    end
                    StInPkt: begin
                        w_store     = 1'b1;
                        w_frame_err = pkt_tx_sop;
                        if (pkt_tx_eop) w_state_nxt = StIdle;
                    end
                    default: w_state_nxt = StIdle;
                endcase
            end
        end
    end

    always_ff @(posedge clk_156m25) begin
        if (reset_156m25_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

`ifdef PKT_MODPORT_ERR_CHECK_EN
    logic r_err_pend;

    // A sop+eop word closing a broken packet carries its own framing error too
    assign w_wr_err = pkt_tx_eop && (r_err_pend || w_frame_err);

    always_ff @(posedge clk_156m25) begin
        if (reset_156m25_n) begin
            r_err_pend <= 1'b0;
        end else if (w_ovf) begin
            r_err_pend <= 1'b1;
        end else if (w_store) begin
            if (pkt_tx_eop) begin
                r_err_pend <= 1'b0;
            end else if (w_frame_err) begin
                r_err_pend <= 1'b1;
            end
        end
    end
`else
    logic w_unused_err;
    assign w_unused_err = w_ovf | w_frame_err;
    assign w_wr_err     = 1'b0;
`endif

    assign w_wr_entry = {pkt_tx_data, pkt_tx_sop, pkt_tx_eop,
                         (pkt_tx_eop ? pkt_tx_mod : 3'd0), w_wr_err};

    always_ff @(posedge clk_156m25) begin
        if (w_store && !reset_156m25_n) begin
            r_mem[r_wptr[PW-2:0]] <= w_wr_entry;
        end
    end

    assign w_cnt_inc = w_store && pkt_tx_eop;
    assign w_cnt_dec = w_pop && w_rd_entry[4];

    always_ff @(posedge clk_156m25) begin
        if (reset_156m25_n) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_pkt_cnt <= '0;
        end else begin
            if (w_store) r_wptr <= r_wptr + 1'b1;
            if (w_pop)   r_rptr <= r_rptr + 1'b1;
            if (w_cnt_inc && !w_cnt_dec) begin
                r_pkt_cnt <= r_pkt_cnt + 1'b1;
            end else if (w_cnt_dec && !w_cnt_inc) begin
                r_pkt_cnt <= r_pkt_cnt - 1'b1;
            end
        end
    end

    // RX output register; data holds its last value when nothing is popped
    always_ff @(posedge clk_156m25) begin
        if (reset_156m25_n) begin
            r_rx_data <= '0;
            r_rx_val  <= 1'b0;
            r_rx_sop  <= 1'b0;
            r_rx_eop  <= 1'b0;
            r_rx_mod  <= '0;
            r_rx_err  <= 1'b0;
        end else if (w_pop) begin
            r_rx_data <= w_rd_entry[69:6];
            r_rx_val  <= 1'b1;
            r_rx_sop  <= w_rd_entry[5];
            r_rx_eop  <= w_rd_entry[4];
            r_rx_mod  <= w_rd_entry[3:1];
            r_rx_err  <= w_rd_entry[0];
        end else begin
            r_rx_val  <= 1'b0;
            r_rx_sop  <= 1'b0;
            r_rx_eop  <= 1'b0;
            r_rx_mod  <= '0;
            r_rx_err  <= 1'b0;
        end
    end

    assign pkt_tx_full  = (w_free <= MARGIN_P);
    assign pkt_rx_avail = (r_pkt_cnt != '0);
    assign pkt_rx_data  = r_rx_data;
    assign pkt_rx_val   = r_rx_val;
    assign pkt_rx_sop   = r_rx_sop;
    assign pkt_rx_eop   = r_rx_eop;
    assign pkt_rx_mod   = r_rx_mod;
    assign pkt_rx_err   = r_rx_err;

endmodule

// File: tb/tb_pkt_modport.sv
// Directed bench for pkt_modport: reset, single packet, empty read, fill/overflow,
// framing error and a streaming read/write run.
module tb_pkt_modport;

`ifdef PKT_MODPORT_ERR_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] tx_data;
    logic        tx_val, tx_sop, tx_eop;
    logic [2:0]  tx_mod;
    logic        tx_full;
    logic        rx_ren;
    logic        rx_avail;
    logic [63:0] rx_data;
    logic        rx_val, rx_sop, rx_eop, rx_err;
    logic [2:0]  rx_mod;

    int checks = 0;
    int errors = 0;

    pkt_modport #(.DEPTH_LOG2(6), .FULL_MARGIN(4)) dut (
        .clk_156m25     (clk),
        .reset_156m25_n (rst),
        .pkt_tx_data    (tx_data),
        .pkt_tx_val     (tx_val),
        .pkt_tx_sop     (tx_sop),
        .pkt_tx_eop     (tx_eop),
        .pkt_tx_mod     (tx_mod),
        .pkt_tx_full    (tx_full),
        .pkt_rx_ren     (rx_ren),
        .pkt_rx_avail   (rx_avail),
        .pkt_rx_data    (rx_data),
        .pkt_rx_val     (rx_val),
        .pkt_rx_sop     (rx_sop),
        .pkt_rx_eop     (rx_eop),
        .pkt_rx_mod     (rx_mod),
        .pkt_rx_err     (rx_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_rx(input string tag, input logic ev, input logic es, input logic ee,
                          input logic [2:0] em, input logic er, input logic [63:0] ed);
        chk({tag, ".val"}, 64'(rx_val), 64'(ev));
        chk({tag, ".sop"}, 64'(rx_sop), 64'(es));
        chk({tag, ".eop"}, 64'(rx_eop), 64'(ee));
        chk({tag, ".mod"}, 64'(rx_mod), 64'(em));
        chk({tag, ".err"}, 64'(rx_err), 64'(er));
        chk({tag, ".data"}, rx_data, ed);
    endtask

    task automatic wr(input logic [63:0] d, input logic s, input logic e, input logic [2:0] m);
        tx_data = d;
        tx_val  = 1'b1;
        tx_sop  = s;
        tx_eop  = e;
        tx_mod  = m;
        tick();
        tx_val  = 1'b0;
        tx_sop  = 1'b0;
        tx_eop  = 1'b0;
        tx_mod  = 3'd0;
    endtask

    function automatic logic [63:0] cdat(input int t);
        return {16'hC0DE, t[15:0], ~t};
    endfunction

    initial begin
        // Reset with busy inputs: they must be ignored
        rst     = 1'b1;
        tx_data = 64'hFFFF_FFFF_FFFF_FFFF;
        tx_val  = 1'b1;
        tx_sop  = 1'b1;
        tx_eop  = 1'b1;
        tx_mod  = 3'd7;
        rx_ren  = 1'b1;
        tick();
        tick();
        tx_val = 1'b0; tx_sop = 1'b0; tx_eop = 1'b0; tx_mod = 3'd0; rx_ren = 1'b0;
        chk_rx("reset", 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 64'h0);
        chk("reset.avail", 64'(rx_avail), 64'd0);
        chk("reset.full", 64'(tx_full), 64'd0);
        rst = 1'b0;
        tick();
        chk("post_reset.avail", 64'(rx_avail), 64'd0);

        // Read from empty FIFO
        rx_ren = 1'b1;
        tick();
        rx_ren = 1'b0;
        chk("empty_read.val", 64'(rx_val), 64'd0);
        chk("empty_read.avail", 64'(rx_avail), 64'd0);

        // Single 3-word packet; mod on a non-EOP word must be stored as 0
        wr(64'h1111_2222_3333_4444, 1'b1, 1'b0, 3'd0);
        chk("pkt1.avail_sop", 64'(rx_avail), 64'd0);
        wr(64'hAAAA_BBBB_CCCC_DDDD, 1'b0, 1'b0, 3'd3);
        wr(64'h5555_6666_7777_8888, 1'b0, 1'b1, 3'd5);
        chk("pkt1.avail_eop", 64'(rx_avail), 64'd1);
        rx_ren = 1'b1;
        tick();
        chk_rx("pkt1.w0", 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 64'h1111_2222_3333_4444);
        tick();
        chk_rx("pkt1.w1", 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 64'hAAAA_BBBB_CCCC_DDDD);
        tick();
        chk_rx("pkt1.w2", 1'b1, 1'b0, 1'b1, 3'd5, 1'b0, 64'h5555_6666_7777_8888);
        chk("pkt1.avail_after", 64'(rx_avail), 64'd0);
        rx_ren = 1'b0;
        tick();
        chk_rx("pkt1.idle_hold", 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 64'h5555_6666_7777_8888);

        // Fill to depth with single-word packets
        for (int i = 0; i < 64; i++) begin
            wr(64'h100 + 64'(i), 1'b1, 1'b1, 3'(i));
            if (i == 58) chk("fill.full_at59", 64'(tx_full), 64'd0);
            if (i == 59) chk("fill.full_at60", 64'(tx_full), 64'd1);
        end
        chk("fill.full_at64", 64'(tx_full), 64'd1);
        wr(64'hDEAD, 1'b1, 1'b1, 3'd1);
        rx_ren = 1'b1;
        tick();
        rx_ren = 1'b0;
        chk_rx("fill.r0", 1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 64'h100);
        wr(64'hBEEF, 1'b1, 1'b1, 3'd2);
        chk("fill.full_refilled", 64'(tx_full), 64'd1);
        rx_ren = 1'b1;
        for (int i = 1; i < 64; i++) begin
            tick();
            chk("fill.rd_data", rx_data, 64'h100 + 64'(i));
            chk("fill.rd_mod", 64'(rx_mod), 64'(i % 8));
            chk("fill.rd_err", 64'(rx_err), 64'd0);
        end
        tick();
        chk_rx("fill.beef", 1'b1, 1'b1, 1'b1, 3'd2, ERR_EN, 64'hBEEF);
        rx_ren = 1'b0;
        chk("fill.avail_drained", 64'(rx_avail), 64'd0);
        chk("fill.full_drained", 64'(tx_full), 64'd0);

        // IDLE word without sop is dropped; then sop,data,sop,eop
        wr(64'hBAD0, 1'b0, 1'b0, 3'd0);
        chk("frame.drop_avail", 64'(rx_avail), 64'd0);
        wr(64'hA0, 1'b1, 1'b0, 3'd0);
        wr(64'hB0, 1'b0, 1'b0, 3'd0);
        wr(64'hC0, 1'b1, 1'b0, 3'd0);
        wr(64'hD0, 1'b0, 1'b1, 3'd0);
        chk("frame.avail", 64'(rx_avail), 64'd1);
        rx_ren = 1'b1;
        tick();
        chk_rx("frame.w0", 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 64'hA0);
        tick();
        chk_rx("frame.w1", 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 64'hB0);
        tick();
        chk_rx("frame.w2", 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 64'hC0);
        tick();
        chk_rx("frame.w3", 1'b1, 1'b0, 1'b1, 3'd0, ERR_EN, 64'hD0);
        tick();
        chk("frame.extra_read_val", 64'(rx_val), 64'd0);
        chk("frame.avail_after", 64'(rx_avail), 64'd0);

        // Streaming: write and read one word per cycle
        for (int t = 0; t < 200; t++) begin
            tx_data = cdat(t);
            tx_val  = 1'b1;
            tx_sop  = (t % 4 == 0);
            tx_eop  = (t % 4 == 3);
            tx_mod  = 3'(t % 8);
            tick();
            chk("stream.full", 64'(tx_full), 64'd0);
            if (t > 0) begin
                chk_rx("stream", 1'b1, ((t - 1) % 4 == 0), ((t - 1) % 4 == 3),
                       (((t - 1) % 4 == 3) ? 3'((t - 1) % 8) : 3'd0), 1'b0, cdat(t - 1));
            end
        end
        tx_val = 1'b0; tx_sop = 1'b0; tx_eop = 1'b0; tx_mod = 3'd0;
        tick();
        chk_rx("stream.last", 1'b1, 1'b0, 1'b1, 3'd7, 1'b0, cdat(199));
        rx_ren = 1'b0;
        tick();
        chk("stream.avail_end", 64'(rx_avail), 64'd0);
        chk("stream.val_end", 64'(rx_val), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
